// File: rtl/pcie_fifo_pkg.sv
// pcie_fifo_pkg: shared defaults and depth helper for the per-VC transmit FIFOs
package pcie_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 4;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/vc_fifo_gen_if.sv
// vc_fifo_gen_if: push/pop, threshold and status bundle of one VC FIFO
interface vc_fifo_gen_if import pcie_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  wr_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_enable;
  logic [ADDR_WIDTH-1:0] umbral_full;
  logic [ADDR_WIDTH-1:0] umbral_empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;
  logic [ADDR_WIDTH:0]   fifo_count;
  modport master (
    output wr_enable, data_in, rd_enable, umbral_full, umbral_empty,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, error, fifo_count
  );
  modport slave (
    input  wr_enable, data_in, rd_enable, umbral_full, umbral_empty,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, error, fifo_count
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: 1W/1R synchronous storage with registered read, no reset
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // read-before-write: a same-address read returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/vc_fifo_gen.sv
// vc_fifo_gen: parametrised VC FIFO with thresholds, occupancy and sticky error
module vc_fifo_gen import pcie_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic clk,
  input logic reset,
  input logic init,
  vc_fifo_gen_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_valid, error, rd_ok, wr_ok, err_ev;
  assign rd_ok  = bus.rd_enable & ~bus.empty;
  assign wr_ok  = bus.wr_enable & (~bus.full | rd_ok);
  assign err_ev = (bus.wr_enable & bus.full & ~rd_ok) | (bus.rd_enable & bus.empty);
  assign bus.full         = count == DEPTH_C;
  assign bus.empty        = count == '0;
  assign bus.almost_full  = count >= DEPTH_C - {1'b0, bus.umbral_full};
  assign bus.almost_empty = count <= {1'b0, bus.umbral_empty};
  assign bus.fifo_count   = count;
  assign bus.rd_valid     = rd_valid;
  assign bus.error        = error;
  assign bus.data_out     = rd_valid ? rd_q : '0;
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk), .we(wr_ok & init), .waddr(wr_ptr), .wdata(bus.data_in),
    .re(rd_ok & init), .raddr(rd_ptr), .rdata(rd_q)
  );
  // pointers, occupancy, pop-valid and sticky error; init is a synchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      error    <= 1'b0;
    end else if (!init) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ok ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr   <= rd_ok ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      count    <= (wr_ok && !rd_ok) ? count + (ADDR_WIDTH+1)'(1) :
                  (rd_ok && !wr_ok) ? count - (ADDR_WIDTH+1)'(1) : count;
      rd_valid <= rd_ok;
      error    <= error | err_ev;
    end
  end
endmodule

// File: tb/tb_vc_fifo_gen.sv
// tb_vc_fifo_gen: directed plus random checks of vc_fifo_gen against a queue model
module tb_vc_fifo_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init = 1'b1;
  int total = 0;
  int bad = 0;
  logic [5:0] q[$];
  bit err_m = 0;
  bit exp_rv = 0;
  logic [5:0] exp_do = '0;

  vc_fifo_gen_if #(.DATA_WIDTH(6), .ADDR_WIDTH(4)) bus ();
  vc_fifo_gen #(.DATA_WIDTH(6), .ADDR_WIDTH(4)) dut (.clk(clk), .reset(reset), .init(init), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(bus.fifo_count), n);
    chk({tag, ".full"}, 32'(bus.full), 32'(n == 16));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= 16 - int'(bus.umbral_full)));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= int'(bus.umbral_empty)));
    chk({tag, ".error"}, 32'(bus.error), 32'(err_m));
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_rv));
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_do));
  endtask

  task automatic clear_model();
    q.delete();
    err_m = 0;
    exp_rv = 0;
    exp_do = '0;
  endtask

  task automatic cyc(input string tag, input bit w, input logic [5:0] d, input bit r, input bit ini = 1'b1);
    bit rok, wok;
    bus.wr_enable = w;
    bus.data_in = d;
    bus.rd_enable = r;
    init = ini;
    if (!ini) clear_model();
    else begin
      rok = r && q.size() > 0;
      wok = w && (q.size() < 16 || rok);
      if ((r && q.size() == 0) || (w && q.size() == 16 && !rok)) err_m = 1;
      exp_rv = rok;
      exp_do = rok ? q.pop_front() : '0;
      if (wok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    init = 1'b1;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in = '0;
    bus.umbral_full = 4'd2;
    bus.umbral_empty = 4'd2;
    #3;
    check_all("reset");
    #4 reset = 1'b1;
    for (int i = 1; i <= 16; i++) cyc("fill", 1'b1, 6'(i), 1'b0);
    for (int i = 0; i < 16; i++) cyc("drain", 1'b0, '0, 1'b1);
    cyc("idle", 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 6'(i + 20), 1'b0);
    cyc("overflow", 1'b1, 6'h3F, 1'b0);
    for (int i = 0; i < 16; i++) cyc("ovf_drain", 1'b0, '0, 1'b1);
    cyc("init1", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc("fill3", 1'b1, 6'(i + 40), 1'b0);
    cyc("full_both", 1'b1, 6'h2A, 1'b1);
    for (int i = 0; i < 16; i++) cyc("drain3", 1'b0, '0, 1'b1);
    cyc("init2", 1'b0, '0, 1'b0, 1'b0);
    cyc("empty_both", 1'b1, 6'h05, 1'b1);
    cyc("pop05", 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cyc("fill10", 1'b1, 6'(i + 7), 1'b0);
    cyc("pop_pre_rst", 1'b0, '0, 1'b1);
    #2 reset = 1'b0;
    clear_model();
    #1 check_all("async_rst");
    #2 reset = 1'b1;
    for (int i = 0; i < 7; i++) cyc("refill", 1'b1, 6'(i + 50), i[0]);
    cyc("init3", 1'b1, 6'h11, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        bus.umbral_full = 4'($urandom_range(0, 15));
        bus.umbral_empty = 4'($urandom_range(0, 15));
      end
      cyc("rand", 1'($urandom_range(0, 99) < 55), 6'($urandom), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 59) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
